// File: rtl/axi_gpio_slave.sv
// AXI4 GPIO responder: OUT/IN/SET/CLR/ID registers with single-beat and INCR/FIXED bursts.
// Define AXI_GPIO_IRQ_EN to add the input-change status register at 0x14 and irq_o.
//
// state  | meaning
// W_IDLE | waiting for write address (awready=1)
// W_DATA | accepting write beats (wready=1)
// W_RESP | holding write response (bvalid=1)
// R_IDLE | waiting for read address (arready=1)
// R_DATA | presenting read beats (rvalid=1)
module axi_gpio_slave #(
    parameter int          ID_WIDTH   = 4,
    parameter int          GPIO_WIDTH = 8,
    parameter logic [31:0] ID_VALUE   = 32'h4750_494F
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,
    input  logic [31:0]           s_awaddr_i,
    input  logic [ID_WIDTH-1:0]   s_awid_i,
    input  logic [7:0]            s_awlen_i,
    input  logic [1:0]            s_awburst_i,
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    input  logic [31:0]           s_wdata_i,
    input  logic [3:0]            s_wstrb_i,
    input  logic                  s_wlast_i,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    output logic [1:0]            s_bresp_o,
    output logic [ID_WIDTH-1:0]   s_bid_o,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    input  logic [31:0]           s_araddr_i,
    input  logic [ID_WIDTH-1:0]   s_arid_i,
    input  logic [7:0]            s_arlen_i,
    input  logic [1:0]            s_arburst_i,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [31:0]           s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic [ID_WIDTH-1:0]   s_rid_o,
    output logic                  s_rlast_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic                  irq_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] IDX_OUT = 3'd0;
    localparam logic [2:0] IDX_IN  = 3'd1;
    localparam logic [2:0] IDX_SET = 3'd2;
    localparam logic [2:0] IDX_CLR = 3'd3;
    localparam logic [2:0] IDX_ID  = 3'd4;
    localparam logic [2:0] IDX_IRQ = 3'd5;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] sync1_q;
    logic [GPIO_WIDTH-1:0] sync2_q;
    logic [GPIO_WIDTH-1:0] irq_sts;

    logic [2:0] aw_idx_q;
    logic [7:0] aw_len_q;
    logic [1:0] aw_burst_q;
    logic [7:0] w_beat_q;
    logic [1:0] w_acc_q;

    logic [2:0] ar_idx_q;
    logic [7:0] ar_len_q;
    logic [1:0] ar_burst_q;
    logic [7:0] r_beat_q;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- write beat decode ----------------
    logic                  w_fire;
    logic                  w_burst_ok;
    logic                  w_mapped;
    logic                  w_en;
    logic [1:0]            w_beat_resp;
    logic [31:0]           strb_mask;
    logic [GPIO_WIDTH-1:0] wmask;
    logic [GPIO_WIDTH-1:0] wbits;

    assign w_fire     = s_wvalid_i & s_wready_o;
    assign w_burst_ok = (aw_burst_q == BURST_FIXED) || (aw_burst_q == BURST_INCR);

    always_comb begin
        w_mapped = 1'b0;
        case (aw_idx_q)
            IDX_OUT, IDX_IN, IDX_SET, IDX_CLR, IDX_ID: w_mapped = 1'b1;
`ifdef AXI_GPIO_IRQ_EN
            IDX_IRQ: w_mapped = 1'b1;
`else
            IDX_IRQ: w_mapped = 1'b0;
`endif
            default: w_mapped = 1'b0;
        endcase
    end

    always_comb begin
        w_beat_resp = RESP_OKAY;
        if (!w_burst_ok)
            w_beat_resp = RESP_SLVERR;
        else if (!w_mapped)
            w_beat_resp = RESP_DECERR;
    end

    always_comb begin
        strb_mask = '0;
        for (int b = 0; b < 4; b++)
            strb_mask[8*b +: 8] = {8{s_wstrb_i[b]}};
    end

    assign wmask = strb_mask[GPIO_WIDTH-1:0];
    assign wbits = s_wdata_i[GPIO_WIDTH-1:0] & wmask;
    assign w_en  = w_fire & w_burst_ok & w_mapped;

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_q <= '0;
        end else if (w_en) begin
            case (aw_idx_q)
                IDX_OUT: out_q <= (out_q & ~wmask) | wbits;
                IDX_SET: out_q <= out_q | wbits;
                IDX_CLR: out_q <= out_q & ~wbits;
                default: out_q <= out_q;
            endcase
        end
    end

    assign gpio_o = out_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef AXI_GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] sync_prev_q;
    logic [GPIO_WIDTH-1:0] irq_clr;
    logic                  irq_q;

    assign irq_clr = (w_en && (aw_idx_q == IDX_IRQ)) ? wbits : '0;

    // A change event in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_prev_q <= '0;
            irq_sts     <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync_prev_q <= sync2_q;
            irq_sts     <= (irq_sts & ~irq_clr) | (sync2_q ^ sync_prev_q);
            irq_q       <= |irq_sts;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_sts = '0;
    assign irq_o   = 1'b0;
`endif

    // ---------------- read beat decode ----------------
    logic [2:0]  rd_idx_next;
    logic [1:0]  rd_burst;
    logic [31:0] rd_value;
    logic [1:0]  rd_resp_next;

    always_comb begin
        if (r_state == R_IDLE) begin
            rd_idx_next = s_araddr_i[4:2];
            rd_burst    = s_arburst_i;
        end else begin
            rd_idx_next = (ar_burst_q == BURST_INCR) ? ar_idx_q + 3'd1 : ar_idx_q;
            rd_burst    = ar_burst_q;
        end
    end

    always_comb begin
        rd_value     = '0;
        rd_resp_next = RESP_OKAY;
        if ((rd_burst != BURST_FIXED) && (rd_burst != BURST_INCR)) begin
            rd_resp_next = RESP_SLVERR;
        end else begin
            case (rd_idx_next)
                IDX_OUT: rd_value[GPIO_WIDTH-1:0] = out_q;
                IDX_IN:  rd_value[GPIO_WIDTH-1:0] = sync2_q;
                IDX_SET, IDX_CLR: rd_value = '0;
                IDX_ID:  rd_value = ID_VALUE;
`ifdef AXI_GPIO_IRQ_EN
                IDX_IRQ: rd_value[GPIO_WIDTH-1:0] = irq_sts;
`else
                IDX_IRQ: rd_resp_next = RESP_DECERR;
`endif
                default: rd_resp_next = RESP_DECERR;
            endcase
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            w_state     <= W_IDLE;
            s_awready_o <= 1'b1;
            s_wready_o  <= 1'b0;
            s_bvalid_o  <= 1'b0;
            s_bresp_o   <= RESP_OKAY;
            s_bid_o     <= '0;
            aw_idx_q    <= '0;
            aw_len_q    <= '0;
            aw_burst_q  <= '0;
            w_beat_q    <= '0;
            w_acc_q     <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_awvalid_i) begin
                        s_bid_o     <= s_awid_i;
                        aw_idx_q    <= s_awaddr_i[4:2];
                        aw_len_q    <= s_awlen_i;
                        aw_burst_q  <= s_awburst_i;
                        w_beat_q    <= '0;
                        w_acc_q     <= RESP_OKAY;
                        s_awready_o <= 1'b0;
                        s_wready_o  <= 1'b1;
                        w_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (s_wlast_i) begin
                            // Burst ends at wlast; a length mismatch is a slave error.
                            s_bresp_o  <= worst(worst(w_acc_q, w_beat_resp),
                                                (w_beat_q != aw_len_q) ? RESP_SLVERR : RESP_OKAY);
                            s_bvalid_o <= 1'b1;
                            s_wready_o <= 1'b0;
                            w_state    <= W_RESP;
                        end else begin
                            w_acc_q  <= worst(w_acc_q, w_beat_resp);
                            w_beat_q <= w_beat_q + 8'd1;
                            if (aw_burst_q == BURST_INCR)
                                aw_idx_q <= aw_idx_q + 3'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready_i) begin
                        s_bvalid_o  <= 1'b0;
                        s_awready_o <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: begin
                    s_awready_o <= 1'b1;
                    s_wready_o  <= 1'b0;
                    s_bvalid_o  <= 1'b0;
                    w_state     <= W_IDLE;
                end
            endcase
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= R_IDLE;
            s_arready_o <= 1'b1;
            s_rvalid_o  <= 1'b0;
            s_rdata_o   <= '0;
            s_rresp_o   <= RESP_OKAY;
            s_rid_o     <= '0;
            s_rlast_o   <= 1'b0;
            ar_idx_q    <= '0;
            ar_len_q    <= '0;
            ar_burst_q  <= '0;
            r_beat_q    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_arvalid_i) begin
                        s_rid_o     <= s_arid_i;
                        ar_len_q    <= s_arlen_i;
                        ar_burst_q  <= s_arburst_i;
                        ar_idx_q    <= rd_idx_next;
                        s_rdata_o   <= rd_value;
                        s_rresp_o   <= rd_resp_next;
                        s_rlast_o   <= (s_arlen_i == 8'd0);
                        r_beat_q    <= '0;
                        s_arready_o <= 1'b0;
                        s_rvalid_o  <= 1'b1;
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_rready_i) begin
                        if (s_rlast_o) begin
                            s_rvalid_o  <= 1'b0;
                            s_rlast_o   <= 1'b0;
                            s_arready_o <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            ar_idx_q  <= rd_idx_next;
                            s_rdata_o <= rd_value;
                            s_rresp_o <= rd_resp_next;
                            r_beat_q  <= r_beat_q + 8'd1;
                            s_rlast_o <= ((r_beat_q + 8'd1) == ar_len_q);
                        end
                    end
                end
                default: begin
                    s_arready_o <= 1'b1;
                    s_rvalid_o  <= 1'b0;
                    r_state     <= R_IDLE;
                end
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_awaddr_i[31:5], s_awaddr_i[1:0], s_araddr_i[31:5], s_araddr_i[1:0],
                           s_wdata_i, strb_mask};

endmodule

// File: tb/tb_axi_gpio_slave.sv
// Directed scoreboard bench for axi_gpio_slave: expected B/R beats queued at issue, checked on handshake.
module tb_axi_gpio_slave;

    localparam int          IDW = 4;
    localparam int          GW  = 8;
    localparam logic [31:0] IDV = 32'h4750_494F;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic            clk_i = 1'b0;
    logic            reset_ni = 1'b0;
    logic            s_awvalid_i = 0, s_awready_o;
    logic [31:0]     s_awaddr_i = '0;
    logic [IDW-1:0]  s_awid_i = '0;
    logic [7:0]      s_awlen_i = '0;
    logic [1:0]      s_awburst_i = '0;
    logic            s_wvalid_i = 0, s_wready_o;
    logic [31:0]     s_wdata_i = '0;
    logic [3:0]      s_wstrb_i = '0;
    logic            s_wlast_i = 0;
    logic            s_bvalid_o, s_bready_i = 0;
    logic [1:0]      s_bresp_o;
    logic [IDW-1:0]  s_bid_o;
    logic            s_arvalid_i = 0, s_arready_o;
    logic [31:0]     s_araddr_i = '0;
    logic [IDW-1:0]  s_arid_i = '0;
    logic [7:0]      s_arlen_i = '0;
    logic [1:0]      s_arburst_i = '0;
    logic            s_rvalid_o, s_rready_i = 0;
    logic [31:0]     s_rdata_o;
    logic [1:0]      s_rresp_o;
    logic [IDW-1:0]  s_rid_o;
    logic            s_rlast_o;
    logic [GW-1:0]   gpio_i = '0;
    logic [GW-1:0]   gpio_o;
    logic            irq_o;

    always #5 clk_i = ~clk_i;

    axi_gpio_slave #(.ID_WIDTH(IDW), .GPIO_WIDTH(GW), .ID_VALUE(IDV)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
        .s_awid_i(s_awid_i), .s_awlen_i(s_awlen_i), .s_awburst_i(s_awburst_i),
        .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i),
        .s_wstrb_i(s_wstrb_i), .s_wlast_i(s_wlast_i),
        .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o), .s_bid_o(s_bid_o),
        .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
        .s_arid_i(s_arid_i), .s_arlen_i(s_arlen_i), .s_arburst_i(s_arburst_i),
        .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o),
        .s_rresp_o(s_rresp_o), .s_rid_o(s_rid_o), .s_rlast_o(s_rlast_o),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .irq_o(irq_o)
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } rexp_t;
    typedef struct { logic [1:0] resp; logic [IDW-1:0] id; } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] wq[$];
    logic [GW-1:0] m_out = '0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [IDW-1:0] id);
        rexp_t e;
        e.data = d; e.resp = r; e.last = l; e.id = id;
        rq.push_back(e);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [IDW-1:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, input logic [3:0] strb,
                             input logic [1:0] exp_resp);
        int t;
        bexp_t e;
        e.resp = exp_resp; e.id = id;
        bq.push_back(e);
        @(negedge clk_i);
        s_awvalid_i = 1; s_awaddr_i = addr; s_awid_i = id; s_awlen_i = len; s_awburst_i = burst;
        t = 0;
        while (!s_awready_o && t < 50) begin @(negedge clk_i); t++; end
        chk("aw_wait", 32'(t < 50), 32'd1);
        @(negedge clk_i);
        s_awvalid_i = 0;
        for (int i = 0; i < nbeats; i++) begin
            s_wvalid_i = 1; s_wdata_i = wq.pop_front(); s_wstrb_i = strb; s_wlast_i = (i == nbeats - 1);
            t = 0;
            while (!s_wready_o && t < 50) begin @(negedge clk_i); t++; end
            chk("w_wait", 32'(t < 50), 32'd1);
            @(negedge clk_i);
        end
        s_wvalid_i = 0; s_wlast_i = 0;
        chk("b_latency", 32'(s_bvalid_o), 32'd1);
        chk("gpio_after_w", 32'(gpio_o), 32'(m_out));
        s_bready_i = 1;
        t = 0;
        while (!s_bvalid_o && t < 50) begin @(negedge clk_i); t++; end
        e = bq.pop_front();
        chk("bresp", 32'(s_bresp_o), 32'(e.resp));
        chk("bid", 32'(s_bid_o), 32'(e.id));
        @(negedge clk_i);
        s_bready_i = 0;
        chk("b_drop", 32'(s_bvalid_o), 32'd0);
        chk("aw_ready_again", 32'(s_awready_o), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [IDW-1:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input bit rand_ready);
        int t;
        rexp_t e;
        @(negedge clk_i);
        s_arvalid_i = 1; s_araddr_i = addr; s_arid_i = id; s_arlen_i = len; s_arburst_i = burst;
        t = 0;
        while (!s_arready_o && t < 50) begin @(negedge clk_i); t++; end
        chk("ar_wait", 32'(t < 50), 32'd1);
        @(negedge clk_i);
        s_arvalid_i = 0;
        chk("r_latency", 32'(s_rvalid_o), 32'd1);
        t = 0;
        while (rq.size() > 0 && t < 500) begin
            s_rready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_rvalid_o) begin
                e = rq[0];
                if (s_rready_i) begin
                    chk("rdata", s_rdata_o, e.data);
                    chk("rresp", 32'(s_rresp_o), 32'(e.resp));
                    chk("rlast", 32'(s_rlast_o), 32'(e.last));
                    chk("rid", 32'(s_rid_o), 32'(e.id));
                    void'(rq.pop_front());
                end else begin
                    chk("rdata_stall", s_rdata_o, e.data);
                end
            end
            @(negedge clk_i);
            t++;
        end
        chk("r_wait", 32'(t < 500), 32'd1);
        s_rready_i = 0;
        chk("r_end_valid", 32'(s_rvalid_o), 32'd0);
        chk("ar_ready_again", 32'(s_arready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk_i);
        chk("rst_awready", 32'(s_awready_o), 32'd1);
        chk("rst_bvalid", 32'(s_bvalid_o), 32'd0);
        reset_ni = 1;
        @(negedge clk_i);
        chk("rst_arready", 32'(s_arready_o), 32'd1);
        chk("rst_wready", 32'(s_wready_o), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid_o), 32'd0);
        chk("rst_gpio", 32'(gpio_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_rdata", s_rdata_o, 32'd0);

        // plain, set and clear writes
        wq.push_back(32'h0000_00A5); m_out = 8'hA5;
        axi_write(32'h00, 4'd3, 8'd0, INCR, 1, 4'hF, OKAY);
        wq.push_back(32'h0000_000F); m_out = 8'hAF;
        axi_write(32'h08, 4'd1, 8'd0, INCR, 1, 4'hF, OKAY);
        wq.push_back(32'h0000_0003); m_out = 8'hAC;
        axi_write(32'h0C, 4'd2, 8'd0, INCR, 1, 4'hF, OKAY);

        // byte strobes: upper lanes only leave OUT alone, lane 0 replaces it
        wq.push_back(32'h1234_56FF);
        axi_write(32'h00, 4'd4, 8'd0, INCR, 1, 4'b1110, OKAY);
        wq.push_back(32'hFFFF_FF3C); m_out = 8'h3C;
        axi_write(32'h00, 4'd4, 8'd0, INCR, 1, 4'b0001, OKAY);

        // input synchronizer latency: FIXED read of IN as gpio_i changes
        gpio_i = 8'h04;
        push_r(32'h0, OKAY, 1'b0, 4'd7);
        push_r(32'h4, OKAY, 1'b0, 4'd7);
        push_r(32'h4, OKAY, 1'b0, 4'd7);
        push_r(32'h4, OKAY, 1'b1, 4'd7);
        axi_read(32'h04, 4'd7, 8'd3, FIXED, 1'b0);

        // INCR burst over the whole map with random backpressure
        push_r(32'(m_out), OKAY, 1'b0, 4'd5);
        push_r(32'h4, OKAY, 1'b0, 4'd5);
        push_r(32'h0, OKAY, 1'b0, 4'd5);
        push_r(32'h0, OKAY, 1'b0, 4'd5);
        push_r(IDV, OKAY, 1'b1, 4'd5);
        axi_read(32'h00, 4'd5, 8'd4, INCR, 1'b1);

        push_r(32'h0, DECERR, 1'b1, 4'd2);
        axi_read(32'h18, 4'd2, 8'd0, INCR, 1'b0);
`ifdef AXI_GPIO_IRQ_EN
        push_r(32'h4, OKAY, 1'b1, 4'd9);
`else
        push_r(32'h0, DECERR, 1'b1, 4'd9);
`endif
        axi_read(32'h14, 4'd9, 8'd0, INCR, 1'b0);
        push_r(32'h0, SLVERR, 1'b0, 4'd1);
        push_r(32'h0, SLVERR, 1'b1, 4'd1);
        axi_read(32'h00, 4'd1, 8'd1, WRAP, 1'b0);

        // error responses on the write channel
        wq.push_back(32'hFF); wq.push_back(32'hFF); wq.push_back(32'hFF);
        axi_write(32'h00, 4'd6, 8'd2, WRAP, 3, 4'hF, SLVERR);
        wq.push_back(32'h11); wq.push_back(32'h99); m_out = 8'h11;
        axi_write(32'h00, 4'd8, 8'd2, INCR, 2, 4'hF, SLVERR);
        wq.push_back(32'h77); m_out = 8'h11;
        axi_write(32'h1C, 4'd10, 8'd0, INCR, 1, 4'hF, DECERR);
        wq.push_back(32'h77); wq.push_back(32'h5A); m_out = 8'h5A;
        axi_write(32'h1C, 4'd11, 8'd1, INCR, 2, 4'hF, DECERR);
        wq.push_back(32'h01); wq.push_back(32'h02); wq.push_back(32'h03); m_out = 8'h03;
        axi_write(32'h00, 4'd12, 8'd2, FIXED, 3, 4'hF, OKAY);
        wq.push_back(32'h04); wq.push_back(32'h01);
        axi_write(32'h04, 4'd13, 8'd1, FIXED, 2, 4'hF, OKAY);

`ifdef AXI_GPIO_IRQ_EN
        chk("irq_set", 32'(irq_o), 32'd1);
        wq.push_back(32'h4);
        axi_write(32'h14, 4'd14, 8'd0, INCR, 1, 4'hF, OKAY);
        @(negedge clk_i);
        chk("irq_cleared", 32'(irq_o), 32'd0);
`else
        chk("irq_tied", 32'(irq_o), 32'd0);
`endif

        // reset in the middle of a 4-beat write
        gpio_i = '0;
        repeat (4) @(negedge clk_i);
        s_awvalid_i = 1; s_awaddr_i = 32'h00; s_awid_i = 4'd6; s_awlen_i = 8'd3; s_awburst_i = FIXED;
        t = 0;
        while (!s_awready_o && t < 50) begin @(negedge clk_i); t++; end
        @(negedge clk_i);
        s_awvalid_i = 0;
        s_wvalid_i = 1; s_wdata_i = 32'h55; s_wstrb_i = 4'hF; s_wlast_i = 0;
        t = 0;
        while (!s_wready_o && t < 50) begin @(negedge clk_i); t++; end
        @(negedge clk_i);
        chk("mid_beat1_gpio", 32'(gpio_o), 32'h55);
        s_wdata_i = 32'h66;
        #2 reset_ni = 0;
        #1;
        chk("mid_rst_bvalid", 32'(s_bvalid_o), 32'd0);
        chk("mid_rst_gpio", 32'(gpio_o), 32'd0);
        chk("mid_rst_wready", 32'(s_wready_o), 32'd0);
        s_wvalid_i = 0;
        @(negedge clk_i);
        reset_ni = 1; m_out = '0;
        @(negedge clk_i);
        chk("post_rst_awready", 32'(s_awready_o), 32'd1);
        repeat (3) @(negedge clk_i);
        chk("post_rst_no_b", 32'(s_bvalid_o), 32'd0);
        chk("post_rst_gpio", 32'(gpio_o), 32'd0);

        wq.push_back(32'h3C); m_out = 8'h3C;
        axi_write(32'h00, 4'd15, 8'd0, INCR, 1, 4'hF, OKAY);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_gpio_slave.md
# axi_gpio_slave

AXI4 responder exposing a GPIO output register, a synchronized GPIO input register and set/clear aliases to an AXI4 initiator such as the UART debug bridge. It sits behind the bridge's address decode, alongside the RAM, and answers single-beat and INCR/FIXED burst transactions on independent read and write channels. Data width is fixed at 32 bits.

## Interface
- ID_WIDTH, 4, AXI ID width
- GPIO_WIDTH, 8, number of GPIO inputs and outputs (1..32)
- ID_VALUE, 32'h4750_494F, constant returned by the ID register
- clk_i  input  1  clock
- reset_ni  input  1  asynchronous active-low reset
- s_awvalid_i / s_awready_o  in/out  1  write-address handshake
- s_awaddr_i  input  32  write address (bits [4:2] decoded, [1:0] ignored)
- s_awid_i  input  ID_WIDTH; s_awlen_i  input  8; s_awburst_i  input  2
- s_wvalid_i / s_wready_o  in/out  1; s_wdata_i  input  32; s_wstrb_i  input  4; s_wlast_i  input  1
- s_bvalid_o / s_bready_i  out/in  1; s_bresp_o  output  2; s_bid_o  output  ID_WIDTH
- s_arvalid_i / s_arready_o  in/out  1; s_araddr_i  input  32; s_arid_i  input  ID_WIDTH; s_arlen_i  input  8; s_arburst_i  input  2
- s_rvalid_o / s_rready_i  out/in  1; s_rdata_o  output  32; s_rresp_o  output  2; s_rid_o  output  ID_WIDTH; s_rlast_o  output  1
- gpio_i  input  GPIO_WIDTH  asynchronous inputs (buttons)
- gpio_o  output  GPIO_WIDTH  output register (LEDs)
- irq_o  output  1  input-change interrupt

## Operation
- Register map (offset = addr[4:0]): 0x00 OUT RW; 0x04 IN RO (synchronized gpio_i); 0x08 SET W1S on OUT; 0x0C CLR W1C on OUT; 0x10 ID RO; 0x14 IRQ_STS (feature-dependent); 0x18–0x1C unmapped.
- Reads of OUT/IN/IRQ_STS zero-extend from GPIO_WIDTH; reads of SET/CLR return 0.
- Writes honour s_wstrb_i per byte; bits at or above GPIO_WIDTH are discarded; writes to IN/ID are ignored with OKAY.
- Unmapped offset: writes ignored, reads return 0, resp DECERR (2'b11) for that beat.
- gpio_i passes through a 2-flop synchronizer before IN and change detection.
- Write FSM: W_IDLE (awready=1) -> on AW handshake latch id/addr/len/burst -> W_DATA (wready=1), one register update per W handshake -> on wlast beat -> W_RESP (bvalid=1) -> on bready -> W_IDLE.
- Read FSM: R_IDLE (arready=1) -> on AR handshake latch, load beat-0 rdata -> R_DATA (rvalid=1), on each R handshake load next beat -> after beat arlen+1 (rlast=1) handshake -> R_IDLE.
- Burst addressing: INCR adds 4 per beat, offset wraps modulo 32; FIXED holds address; WRAP (2'b10) and 2'b11: no register effect, every beat responds SLVERR (2'b10).
- bresp: worst of all beats (DECERR > SLVERR > OKAY); SLVERR also if wlast arrives on a beat other than awlen+1 (burst ends at wlast).
- Read and write channels are independent; same-cycle read of a register being written returns the pre-write value.
- SET and CLR hitting the same bit in one beat impossible (distinct offsets); a write beat to OUT is a full replace under strobes.

## Timing
- Reset values: all valid outputs 0, awready=1, arready=1, wready=0, rdata/rresp/bresp/rid/bid/rlast 0, gpio_o 0, irq_o 0, synchronizer 0, beat counters 0.
- Reset asserted mid-burst aborts immediately; FSMs return to idle, no response issued.
- Write register update visible on gpio_o the cycle after the W handshake.
- bvalid asserts the cycle after the wlast handshake; AW accepted again the cycle after B handshake.
- rvalid asserts the cycle after AR handshake; back-to-back beats with rready held high give one beat per cycle.
- gpio_i to IN latency: 2 cycles.
- valid outputs stay asserted, payload stable, until handshake.

## Configuration
- AXI_GPIO_IRQ_EN defined: IRQ_STS at 0x14 latches a 1 per bit on any change of synchronized input; write-1-clears; a set event in the same cycle as a clear wins; irq_o = OR of IRQ_STS, registered.
- Undefined: irq_o tied 0, no status flops, 0x14 treated as unmapped (DECERR).

## Test plan
- Single write 0x0000_00A5 strobe 4'hF to 0x00 -> gpio_o=8'hA5, bresp OKAY, bid echoes awid=3.
- Write 0x0F to 0x08 then 0x03 to 0x0C with gpio_o=8'hA5 -> gpio_o=8'hAF then 8'hAC.
- INCR read arlen=4 from 0x00 -> 5 beats: OUT, IN, 0, 0, ID_VALUE; rlast only on beat 5; rresp OKAY; rready toggled randomly, data stable while stalled.
- Read 0x18 single beat -> rdata 0, rresp DECERR; WRAP write burst len 2 -> gpio_o unchanged, bresp SLVERR.
- gpio_i 0->4'b0100 -> IN reads 0x4 two cycles later; with AXI_GPIO_IRQ_EN irq_o=1, write 0x4 to 0x14 -> irq_o=0.
- Assert reset_ni low during beat 2 of a 4-beat write -> no bvalid, gpio_o=0, awready=1 after release.
